// File: rtl/rf_issue_pkg.sv
// Shared types and helpers for the operand-issue lane.
package rf_issue_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int RF_NREG   = 1 << RF_ADDR_W;

  typedef struct packed {
    logic [RF_DATA_W-1:0] rs1_val;
    logic [RF_DATA_W-1:0] rs2_val;
    logic [RF_ADDR_W-1:0] rd;
  } issue_t;

  // One-hot register select; x0 never carries state, so bit 0 stays clear.
  function automatic logic [RF_NREG-1:0] onehot_idx(input logic [RF_ADDR_W-1:0] addr);
    logic [RF_NREG-1:0] v;
    v       = '0;
    v[addr] = 1'b1;
    v[0]    = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/rf_operand_issue_scoreboard.sv
// Pending-write scoreboard for one lane: busy vector, set/clear, hazard lookup.
// RF_OPERAND_BYPASS_EN: same-cycle writebacks mask the busy view used for hazards.
module rf_scoreboard
  import rf_issue_pkg::*;
#(
  parameter int addr_w = RF_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [(1<<addr_w)-1:0] clr,
  input  logic [(1<<addr_w)-1:0] x_busy,
  input  logic                   set_en,
  input  logic [addr_w-1:0]      set_idx,
  input  logic [addr_w-1:0]      rs1,
  input  logic [addr_w-1:0]      rs2,
  input  logic [addr_w-1:0]      rd,
  input  logic                   rd_we,
  output logic [(1<<addr_w)-1:0] busy,
  output logic                   hazard
);

  localparam int nreg = 1 << addr_w;

  logic [nreg-1:0] eb;
  logic [nreg-1:0] set_vec;

  // Effective busy view combining both lanes' pending writes.
  always_comb begin
    eb = busy | x_busy;
`ifdef RF_OPERAND_BYPASS_EN
    eb = eb & ~clr;
`endif
  end

  assign hazard = ((rs1 != '0) && eb[rs1]) ||
                  ((rs2 != '0) && eb[rs2]) ||
                  (rd_we && (rd != '0) && eb[rd]);

  assign set_vec = set_en ? onehot_idx(set_idx) : '0;

  // Busy update: clear retiring writes, then set the newly issued destination.
  always_ff @(posedge clk) begin
    if (rst)
      busy <= '0;
    else
      busy <= ((busy & ~clr) | set_vec) & {{(nreg-1){1'b1}}, 1'b0};
  end

endmodule

// File: rtl/rf_operand_issue.sv
// Operand-issue lane: drives regfile read/write ports, tracks hazards and
// presents captured operands on a registered valid/ready issue port.
// Optional feature macro: RF_OPERAND_BYPASS_EN (writeback forwarding).
module rf_operand_issue
  import rf_issue_pkg::*;
#(
  parameter int addr_w = RF_ADDR_W,
  parameter int data_w = RF_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dec_valid,
  output logic                   dec_ready,
  input  logic [addr_w-1:0]      dec_rs1,
  input  logic [addr_w-1:0]      dec_rs2,
  input  logic [addr_w-1:0]      dec_rd,
  input  logic                   dec_rd_we,
  output logic [addr_w-1:0]      rf_rs1_addr,
  output logic [addr_w-1:0]      rf_rs2_addr,
  input  logic [data_w-1:0]      rf_rs1_data,
  input  logic [data_w-1:0]      rf_rs2_data,
  output logic [addr_w-1:0]      rf_rd_addr,
  output logic [data_w-1:0]      rf_rd_data,
  input  logic                   wb_valid,
  input  logic [addr_w-1:0]      wb_addr,
  input  logic [data_w-1:0]      wb_data,
  input  logic                   xwb_valid,
  input  logic [addr_w-1:0]      xwb_addr,
  input  logic [data_w-1:0]      xwb_data,
  input  logic [(1<<addr_w)-1:0] x_busy,
  output logic [(1<<addr_w)-1:0] busy,
  output logic                   iss_valid,
  input  logic                   iss_ready,
  output logic [data_w-1:0]      iss_rs1_val,
  output logic [data_w-1:0]      iss_rs2_val,
  output logic [addr_w-1:0]      iss_rd
);

  logic [(1<<addr_w)-1:0] clr;
  logic                   hazard;
  logic                   slot_free;
  logic                   accept;
  issue_t                 iss_p0;
  issue_t                 iss_p1;

  // Per-source operand selection; x0 always reads as zero.
  function automatic logic [data_w-1:0] pick(input logic [addr_w-1:0] rs,
                                             input logic [data_w-1:0] rf_val);
    if (rs == '0)
      return '0;
`ifdef RF_OPERAND_BYPASS_EN
    if (wb_valid && (wb_addr == rs))
      return wb_data;
    if (xwb_valid && (xwb_addr == rs))
      return xwb_data;
`endif
    return rf_val;
  endfunction

`ifndef RF_OPERAND_BYPASS_EN
  logic unused_xwb_data;
  assign unused_xwb_data = ^xwb_data;
`endif

  assign rf_rs1_addr = dec_rs1;
  assign rf_rs2_addr = dec_rs2;
  assign rf_rd_addr  = wb_valid ? wb_addr : '0;
  assign rf_rd_data  = wb_data;

  assign clr = (wb_valid  ? onehot_idx(wb_addr)  : '0) |
               (xwb_valid ? onehot_idx(xwb_addr) : '0);

  assign slot_free = !iss_valid || iss_ready;
  assign dec_ready = slot_free && !hazard;
  assign accept    = dec_valid && dec_ready;

  rf_scoreboard #(.addr_w(addr_w)) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .x_busy  (x_busy),
    .set_en  (accept && dec_rd_we && (dec_rd != '0)),
    .set_idx (dec_rd),
    .rs1     (dec_rs1),
    .rs2     (dec_rs2),
    .rd      (dec_rd),
    .rd_we   (dec_rd_we),
    .busy    (busy),
    .hazard  (hazard)
  );

  // p0: operands as selected this cycle for the presented instruction
  assign iss_p0.rs1_val = pick(dec_rs1, rf_rs1_data);
  assign iss_p0.rs2_val = pick(dec_rs2, rf_rs2_data);
  assign iss_p0.rd      = dec_rd_we ? dec_rd : '0;

  // p1: issue register; captures on accept, holds while the slot is occupied
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_valid <= 1'b0;
      iss_p1    <= '0;
    end else if (accept) begin
      iss_valid <= 1'b1;
      iss_p1    <= iss_p0;
    end else if (iss_ready) begin
      iss_valid <= 1'b0;
    end
  end

  assign iss_rs1_val = iss_p1.rs1_val;
  assign iss_rs2_val = iss_p1.rs2_val;
  assign iss_rd      = iss_p1.rd;

endmodule

// File: tb/tb_rf_operand_issue.sv
// Directed bench for rf_operand_issue with a small behavioural regfile.
module tb_rf_operand_issue;

  logic        clk;
  logic        rst;
  logic        dec_valid;
  logic        dec_ready;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_rd_we;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        xwb_valid;
  logic [4:0]  xwb_addr;
  logic [31:0] xwb_data;
  logic [31:0] x_busy;
  logic [31:0] busy;
  logic        iss_valid;
  logic        iss_ready;
  logic [31:0] iss_rs1_val, iss_rs2_val;
  logic [4:0]  iss_rd;

  int checks = 0;
  int errors = 0;

  logic [31:0] regs [32];

  rf_operand_issue dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_rd_we(dec_rd_we),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .xwb_valid(xwb_valid), .xwb_addr(xwb_addr), .xwb_data(xwb_data),
    .x_busy(x_busy), .busy(busy),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs1_val(iss_rs1_val), .iss_rs2_val(iss_rs2_val), .iss_rd(iss_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Regfile model: commits this lane's RdAddr and the other lane's writeback.
  always @(posedge clk) begin
    if (rf_rd_addr != 5'd0) regs[rf_rd_addr] <= rf_rd_data;
    if (xwb_valid && xwb_addr != 5'd0) regs[xwb_addr] <= xwb_data;
  end
  assign rf_rs1_data = regs[rf_rs1_addr];
  assign rf_rs2_data = regs[rf_rs2_addr];

  // Illegal stimulus guard: both lanes writing one index in the same cycle.
  always @(posedge clk) begin
    if (wb_valid && xwb_valid && wb_addr == xwb_addr) begin
      errors++;
      $display("FAIL wb_collision addr %0d", wb_addr);
    end
  end

  task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk); wb_valid = 1'b1; wb_addr = a; wb_data = d;
    @(negedge clk); wb_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk); rst = 1'b1; wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
    #1;
    checks++; if (rf_rd_addr !== 5'd9) begin errors++; $display("FAIL rst_rd_addr got %h exp %h", rf_rd_addr, 5'd9); end
    checks++; if (rf_rd_data !== 32'h99) begin errors++; $display("FAIL rst_rd_data got %h exp %h", rf_rd_data, 32'h99); end
    @(negedge clk); wb_valid = 1'b0;
    #1;
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL rst_busy got %h exp 0", busy); end
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL rst_iss_valid got %b exp 0", iss_valid); end
    checks++; if (iss_rs1_val !== 32'h0) begin errors++; $display("FAIL rst_rs1_val got %h exp 0", iss_rs1_val); end
    checks++; if (iss_rs2_val !== 32'h0) begin errors++; $display("FAIL rst_rs2_val got %h exp 0", iss_rs2_val); end
    checks++; if (iss_rd !== 5'd0) begin errors++; $display("FAIL rst_iss_rd got %h exp 0", iss_rd); end
    checks++; if (rf_rd_addr !== 5'd0) begin errors++; $display("FAIL rst_rd_addr_idle got %h exp 0", rf_rd_addr); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_independent;
    @(negedge clk); iss_ready = 1'b1; dec_valid = 1'b1;
    dec_rs1 = 5'd1; dec_rs2 = 5'd2; dec_rd = 5'd3; dec_rd_we = 1'b1;
    #1;
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL ind_ready got %b exp 1", dec_ready); end
    @(negedge clk); dec_valid = 1'b0;
    #1;
    checks++; if (iss_valid !== 1'b1) begin errors++; $display("FAIL ind_valid got %b exp 1", iss_valid); end
    checks++; if (iss_rs1_val !== 32'h11) begin errors++; $display("FAIL ind_rs1 got %h exp %h", iss_rs1_val, 32'h11); end
    checks++; if (iss_rs2_val !== 32'h22) begin errors++; $display("FAIL ind_rs2 got %h exp %h", iss_rs2_val, 32'h22); end
    checks++; if (iss_rd !== 5'd3) begin errors++; $display("FAIL ind_rd got %h exp 3", iss_rd); end
    checks++; if (busy !== 32'h8) begin errors++; $display("FAIL ind_busy got %h exp %h", busy, 32'h8); end
    @(negedge clk); #1;
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL ind_drain got %b exp 0", iss_valid); end
    rf_write(5'd3, 32'h33);
    #1;
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL ind_clear got %h exp 0", busy); end
  endtask

  task automatic test_raw;
    @(negedge clk); dec_valid = 1'b1; dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rd = 5'd5; dec_rd_we = 1'b1;
    #1;
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL raw_prod_ready got %b exp 1", dec_ready); end
    @(negedge clk); dec_rs1 = 5'd5; dec_rs2 = 5'd2; dec_rd = 5'd8; dec_rd_we = 1'b1;
    #1;
    checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL raw_stall0 got %b exp 0", dec_ready); end
    @(negedge clk); #1;
    checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL raw_stall1 got %b exp 0", dec_ready); end
    @(negedge clk); wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    #1;
`ifdef RF_OPERAND_BYPASS_EN
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL raw_wb_ready got %b exp 1", dec_ready); end
    @(negedge clk); wb_valid = 1'b0; dec_valid = 1'b0;
`else
    checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL raw_wb_ready got %b exp 0", dec_ready); end
    @(negedge clk); wb_valid = 1'b0;
    #1;
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL raw_late_ready got %b exp 1", dec_ready); end
    @(negedge clk); dec_valid = 1'b0;
`endif
    #1;
    checks++; if (iss_rs1_val !== 32'hDEADBEEF) begin errors++; $display("FAIL raw_rs1 got %h exp %h", iss_rs1_val, 32'hDEADBEEF); end
    checks++; if (iss_rs2_val !== 32'h22) begin errors++; $display("FAIL raw_rs2 got %h exp %h", iss_rs2_val, 32'h22); end
    checks++; if (busy !== 32'h100) begin errors++; $display("FAIL raw_busy got %h exp %h", busy, 32'h100); end
  endtask

  task automatic test_cross_lane;
    @(negedge clk); x_busy = 32'h80; dec_valid = 1'b1;
    dec_rs1 = 5'd1; dec_rs2 = 5'd7; dec_rd = 5'd0; dec_rd_we = 1'b0;
    #1;
    checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL xl_stall got %b exp 0", dec_ready); end
    @(negedge clk); xwb_valid = 1'b1; xwb_addr = 5'd7; xwb_data = 32'h1234;
    #1;
`ifdef RF_OPERAND_BYPASS_EN
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL xl_wb_ready got %b exp 1", dec_ready); end
    @(negedge clk); x_busy = 32'h0; xwb_valid = 1'b0; dec_valid = 1'b0;
`else
    checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL xl_wb_ready got %b exp 0", dec_ready); end
    @(negedge clk); x_busy = 32'h0; xwb_valid = 1'b0;
    #1;
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL xl_late_ready got %b exp 1", dec_ready); end
    @(negedge clk); dec_valid = 1'b0;
`endif
    #1;
    checks++; if (iss_valid !== 1'b1) begin errors++; $display("FAIL xl_valid got %b exp 1", iss_valid); end
    checks++; if (iss_rs1_val !== 32'h11) begin errors++; $display("FAIL xl_rs1 got %h exp %h", iss_rs1_val, 32'h11); end
    checks++; if (iss_rs2_val !== 32'h1234) begin errors++; $display("FAIL xl_rs2 got %h exp %h", iss_rs2_val, 32'h1234); end
    checks++; if (iss_rd !== 5'd0) begin errors++; $display("FAIL xl_rd got %h exp 0", iss_rd); end
    checks++; if (busy !== 32'h100) begin errors++; $display("FAIL xl_busy got %h exp %h", busy, 32'h100); end
  endtask

  task automatic test_backpressure;
    @(negedge clk); iss_ready = 1'b0; dec_valid = 1'b1;
    dec_rs1 = 5'd1; dec_rs2 = 5'd2; dec_rd = 5'd0; dec_rd_we = 1'b0;
    #1;
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL bp_first_ready got %b exp 1", dec_ready); end
    @(negedge clk); dec_rs1 = 5'd2; dec_rs2 = 5'd1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %b exp 0", i, dec_ready); end
      checks++; if (iss_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b exp 1", i, iss_valid); end
      checks++; if (iss_rs1_val !== 32'h11 || iss_rs2_val !== 32'h22) begin
        errors++; $display("FAIL bp_hold[%0d] got %h/%h exp 11/22", i, iss_rs1_val, iss_rs2_val);
      end
    end
    @(negedge clk); iss_ready = 1'b1;
    #1;
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", dec_ready); end
    @(negedge clk); dec_valid = 1'b0;
    #1;
    checks++; if (iss_rs1_val !== 32'h22 || iss_rs2_val !== 32'h11) begin
      errors++; $display("FAIL bp_next got %h/%h exp 22/11", iss_rs1_val, iss_rs2_val);
    end
    checks++; if (iss_valid !== 1'b1) begin errors++; $display("FAIL bp_next_valid got %b exp 1", iss_valid); end
  endtask

  task automatic test_x0_waw;
    @(negedge clk); dec_valid = 1'b1; dec_rs1 = 5'd0; dec_rs2 = 5'd2; dec_rd = 5'd0; dec_rd_we = 1'b1;
    #1;
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got %b exp 1", dec_ready); end
    @(negedge clk); dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rd = 5'd4; dec_rd_we = 1'b1;
    #1;
    checks++; if (iss_rs1_val !== 32'h0) begin errors++; $display("FAIL x0_rs1 got %h exp 0", iss_rs1_val); end
    checks++; if (iss_rs2_val !== 32'h22) begin errors++; $display("FAIL x0_rs2 got %h exp %h", iss_rs2_val, 32'h22); end
    checks++; if (iss_rd !== 5'd0) begin errors++; $display("FAIL x0_rd got %h exp 0", iss_rd); end
    checks++; if (busy !== 32'h100) begin errors++; $display("FAIL x0_busy got %h exp %h", busy, 32'h100); end
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL waw_first_ready got %b exp 1", dec_ready); end
    @(negedge clk); #1;
    checks++; if (busy !== 32'h110) begin errors++; $display("FAIL waw_busy got %h exp %h", busy, 32'h110); end
    checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL waw_stall got %b exp 0", dec_ready); end
    @(negedge clk); wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h44;
    #1;
`ifdef RF_OPERAND_BYPASS_EN
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL waw_wb_ready got %b exp 1", dec_ready); end
    @(negedge clk); wb_valid = 1'b0; dec_valid = 1'b0;
`else
    checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL waw_wb_ready got %b exp 0", dec_ready); end
    @(negedge clk); wb_valid = 1'b0;
    #1;
    checks++; if (busy !== 32'h100) begin errors++; $display("FAIL waw_cleared got %h exp %h", busy, 32'h100); end
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL waw_late_ready got %b exp 1", dec_ready); end
    @(negedge clk); dec_valid = 1'b0;
`endif
    #1;
    checks++; if (busy !== 32'h110) begin errors++; $display("FAIL waw_setwins got %h exp %h", busy, 32'h110); end
    checks++; if (iss_rd !== 5'd4) begin errors++; $display("FAIL waw_rd got %h exp 4", iss_rd); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk); iss_ready = 1'b0; dec_valid = 1'b1;
    dec_rs1 = 5'd1; dec_rs2 = 5'd0; dec_rd = 5'd0; dec_rd_we = 1'b0;
    #1;
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL rm_ready got %b exp 1", dec_ready); end
    @(negedge clk); dec_valid = 1'b0;
    @(negedge clk); #1;
    checks++; if (iss_valid !== 1'b1) begin errors++; $display("FAIL rm_held got %b exp 1", iss_valid); end
    checks++; if (busy !== 32'h110) begin errors++; $display("FAIL rm_busy_pre got %h exp %h", busy, 32'h110); end
    @(negedge clk); rst = 1'b1; wb_valid = 1'b1; wb_addr = 5'd10; wb_data = 32'hAA;
    #1;
    checks++; if (rf_rd_addr !== 5'd10) begin errors++; $display("FAIL rm_rd_addr got %h exp %h", rf_rd_addr, 5'd10); end
    @(negedge clk); rst = 1'b0; wb_valid = 1'b0;
    #1;
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got %b exp 0", iss_valid); end
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL rm_busy got %h exp 0", busy); end
    checks++; if (iss_rs1_val !== 32'h0) begin errors++; $display("FAIL rm_rs1 got %h exp 0", iss_rs1_val); end
    @(negedge clk); iss_ready = 1'b1; dec_valid = 1'b1; dec_rs1 = 5'd10; dec_rs2 = 5'd0;
    #1;
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL rm_post_ready got %b exp 1", dec_ready); end
    @(negedge clk); dec_valid = 1'b0;
    #1;
    checks++; if (iss_rs1_val !== 32'hAA) begin errors++; $display("FAIL rm_wb_committed got %h exp %h", iss_rs1_val, 32'hAA); end
  endtask

  initial begin
    rst = 1'b1; dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0; dec_rd_we = 1'b0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    xwb_valid = 1'b0; xwb_addr = '0; xwb_data = '0;
    x_busy = '0; iss_ready = 1'b1;
    test_reset;
    rf_write(5'd1, 32'h11);
    rf_write(5'd2, 32'h22);
    test_independent;
    test_raw;
    test_cross_lane;
    test_backpressure;
    test_x0_waw;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_operand_issue.md
Name: rf_operand_issue

Overview:
- Register-file-facing initiator for one issue lane: the "to_rf" end of the single-write, dual-read regfile port pair consumed by the quad-read regfile.
- Accepts decoded instructions and drives Rs1/Rs2 read addresses.
- Tracks pending destination writes in a scoreboard, stalls on RAW/WAW hazards and forwards same-cycle writebacks.
- Presents operands on a registered valid/ready issue port, and drives the lane's writeback onto RdAddr/RdData.

Parameters:
addr_w, 5, register address width (2**addr_w architectural registers; x0 hardwired zero)
data_w, 32, register data width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
dec_valid  in  1  decoded instruction available
dec_ready  out  1  instruction accepted this cycle when dec_valid & dec_ready
dec_rs1  in  addr_w  source 1 index
dec_rs2  in  addr_w  source 2 index
dec_rd  in  addr_w  destination index
dec_rd_we  in  1  instruction writes dec_rd
rf_rs1_addr  out  addr_w  to regfile Rs1Addr (= dec_rs1)
rf_rs2_addr  out  addr_w  to regfile Rs2Addr (= dec_rs2)
rf_rs1_data  in  data_w  from regfile Rs1Data (asynchronous read)
rf_rs2_data  in  data_w  from regfile Rs2Data
rf_rd_addr  out  addr_w  to regfile RdAddr (0 = no write)
rf_rd_data  out  data_w  to regfile RdData
wb_valid  in  1  local lane writeback
wb_addr  in  addr_w  local writeback index
wb_data  in  data_w  local writeback data
xwb_valid  in  1  other lane writeback (already on its RdAddr)
xwb_addr  in  addr_w  other lane writeback index
xwb_data  in  data_w  other lane writeback data
x_busy  in  2**addr_w  other lane scoreboard
busy  out  2**addr_w  this lane scoreboard (registered)
iss_valid  out  1  operands valid
iss_ready  in  1  downstream accepts
iss_rs1_val  out  data_w  operand 1
iss_rs2_val  out  data_w  operand 2
iss_rd  out  addr_w  destination (0 if no write)

Behaviour:
- Reset: busy=0, iss_valid=0, iss_rs1_val=0, iss_rs2_val=0, iss_rd=0. rf_rd_addr follows wb inputs combinationally.
- Writeback:
  - rf_rd_addr = wb_valid ? wb_addr : 0.
  - rf_rd_data = wb_data.
  - Regfile commits at the next clk edge.
- Clear vector:
  - clr = onehot(wb_addr) if wb_valid, OR onehot(xwb_addr) if xwb_valid.
  - Bit 0 is always ignored.
- Effective busy: eb = (busy | x_busy) & ~clr.
- Hazard:
  - (dec_rs1!=0 & eb[dec_rs1]) | (dec_rs2!=0 & eb[dec_rs2]) | (dec_rd_we & dec_rd!=0 & eb[dec_rd]).
- Slot free: !iss_valid | iss_ready.
- dec_ready = slot_free & !hazard. It is combinational and may depend on dec_* inputs.
- Operand select, per source, by priority:
  1. Index 0 selects 0.
  2. wb_valid & wb_addr==rs selects wb_data.
  3. xwb_valid & xwb_addr==rs selects xwb_data.
  4. Otherwise rf_*_data.
- Both writebacks to the same index in one cycle is illegal; the bench asserts against it.
- On accept:
  - Capture operands into iss_*.
  - iss_rd = dec_rd_we ? dec_rd : 0.
  - iss_valid=1.
  - Latency from accept to iss_valid is 1 cycle.
- Held operands: if !slot_free, iss_* hold stable. Captured operands never change afterwards; they were hazard-free at capture.
- iss_valid & iss_ready without a new accept clears iss_valid.
- Scoreboard next state: busy_next = (busy & ~clr) | (accept & dec_rd_we & dec_rd!=0 ? onehot(dec_rd) : 0). Set wins over a same-cycle clear of the same index.
- busy[0] is always 0.
- A writeback to a non-busy index still writes the regfile; its clear is a no-op.
- Reset mid-operation: pending busy bits and a held issue are discarded. Writebacks in the reset cycle still reach the regfile.

Optional Feature:
- Macro RF_OPERAND_BYPASS_EN.
- Defined: clr-masking of eb and operand forwarding from wb/xwb as above. A dependent instruction issues in the same cycle as its producer's writeback.
- Undefined:
  - eb = busy | x_busy with no clr masking, and operands come only from rf_*_data (x0 still forced 0).
  - A dependent instruction issues the cycle after writeback, reading committed regfile data.
  - Scoreboard clear timing is unchanged.

Decomposition:
- Package rf_issue_pkg holds:
  - issue_t struct {rs1_val, rs2_val, rd}, parameterised via data_w/addr_w localparams RF_ADDR_W=5, RF_DATA_W=32.
  - function onehot_idx(addr) returning a 2**addr_w vector with bit 0 masked.
- Sub-module rf_scoreboard holds the busy vector, set/clear logic and hazard lookup. It is instantiated once.

Test Plan:
- Independent stream: after reset, issue rs1=1, rs2=2, rd=3, with the regfile holding x1=0x11 and x2=0x22 -> next cycle iss_valid=1, iss_rs1_val=0x11, iss_rs2_val=0x22, iss_rd=3, busy[3]=1.
- RAW with bypass: x5 busy; instruction rs1=5 waits; wb_valid, wb_addr=5, wb_data=0xDEADBEEF -> dec_ready=1 that cycle, iss_rs1_val=0xDEADBEEF, busy[5]=0. Without the macro: accept one cycle later with the same value.
- Cross-lane: x_busy[7]=1 stalls rs2=7. xwb_addr=7, xwb_data=0x1234 -> issue with iss_rs2_val=0x1234.
- Backpressure: iss_ready=0 for 3 cycles -> dec_ready=0 and iss_* stable. Raise iss_ready -> next instruction is accepted in the same cycle.
- x0 / WAW: rs1=0, rd=0 with dec_rd_we -> operand 0, no busy bit set. rd=4 while busy[4] -> stall until clear. A same-cycle clear and set on 4 leaves busy[4]=1.
- Reset while iss_valid=1 and busy=0x0000_0110 -> next cycle iss_valid=0, busy=0.
